// File: rtl/mem_sram_ctrl_if.sv
// Bus bundle between the EX/MEM pipeline, the SRAM controller and the 16-bit external SRAM.
// slave: controller side; master: pipeline + SRAM device side.
interface mem_sram_ctrl_if;
    logic        wb_en_in;
    logic        mem_r_en_in;
    logic        mem_w_en_in;
    logic [31:0] alu_result_in;
    logic [3:0]  dest_in;
    logic [31:0] st_val_in;

    logic        wb_en;
    logic        mem_r_en;
    logic [31:0] alu_result;
    logic [3:0]  dest;
    logic [31:0] data_memory_out;
    logic        freeze;

    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    modport slave (
        input  wb_en_in, mem_r_en_in, mem_w_en_in, alu_result_in, dest_in, st_val_in,
        input  sram_dq_in,
        output wb_en, mem_r_en, alu_result, dest, data_memory_out, freeze,
        output sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport master (
        output wb_en_in, mem_r_en_in, mem_w_en_in, alu_result_in, dest_in, st_val_in,
        output sram_dq_in,
        input  wb_en, mem_r_en, alu_result, dest, data_memory_out, freeze,
        input  sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/mem_sram_ctrl.sv
// MEM-stage SRAM controller: each 32-bit load/store becomes two 16-bit SRAM accesses (low, then high).
// Optional macro MEM_BOUNDS_CHECK_EN: requests outside the SRAM window complete at once with no strobes.
module mem_sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input logic            clk,
    input logic            rst,
    mem_sram_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOW  = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [3:0] RELOAD = 4'(WAIT_CYCLES - 1);

    logic [1:0]  state;
    logic [3:0]  wait_cnt;
    logic [31:0] rd_data;

    logic [31:0] offset;
    logic [16:0] word_idx;
    logic [12:0] idx_hi;
    logic        req;
    logic        is_write;
    logic        is_read;
    logic        in_range;
    logic        start;
    logic        active;
    logic        half;
    logic        cnt_zero;
    logic        unused_bits;

    assign bus.wb_en      = bus.wb_en_in;
    assign bus.mem_r_en   = bus.mem_r_en_in;
    assign bus.alu_result = bus.alu_result_in;
    assign bus.dest       = bus.dest_in;

    // Byte offset into the SRAM window; wraps freely when the address is below BASE_ADDR.
    assign offset      = bus.alu_result_in - BASE_ADDR;
    assign word_idx    = offset[18:2];
    assign idx_hi      = offset[31:19];
    assign unused_bits = ^{offset[1:0], idx_hi};

    assign req      = bus.mem_r_en_in | bus.mem_w_en_in;
    assign is_write = bus.mem_w_en_in;
    assign is_read  = bus.mem_r_en_in & ~bus.mem_w_en_in;

`ifdef MEM_BOUNDS_CHECK_EN
    assign in_range = (bus.alu_result_in >= BASE_ADDR) && (idx_hi == '0);
`else
    assign in_range = 1'b1;
`endif

    assign start    = (state == IDLE) && req && in_range;
    assign active   = (state == LOW) || (state == HIGH);
    assign half     = (state == HIGH);
    assign cnt_zero = (wait_cnt == '0);

    // The request cycle itself is frozen, so the stall begins before the FSM leaves IDLE.
    assign bus.freeze    = rst & (start | active);
    assign bus.sram_addr = {word_idx, half};

    // NOTE: strobes are decoded from the registered state only, never from a latch-prone if without else.
    assign bus.sram_we_n  = ~(active & is_write);
    assign bus.sram_dq_oe = active & is_write;

    always_comb begin
        bus.sram_dq_out = '0;
        if (active && is_write) begin
            bus.sram_dq_out = half ? bus.st_val_in[31:16] : bus.st_val_in[15:0];
        end
    end

    assign bus.data_memory_out = rd_data;

    // NOTE: all state updates use non-blocking assignment so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            rd_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOW;
                        wait_cnt <= RELOAD;
                    end else if (is_read && !in_range) begin
                        rd_data <= '0;
                    end
                end
                LOW: begin
                    if (cnt_zero) begin
                        state    <= HIGH;
                        wait_cnt <= RELOAD;
                        if (is_read) rd_data[15:0] <= bus.sram_dq_in;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                HIGH: begin
                    if (cnt_zero) begin
                        state <= DONE;
                        if (is_read) rd_data[31:16] <= bus.sram_dq_in;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
